serial_tx: RTL and testbench
============================

// Module: serial_tx
// PURPOSE
//  Frame transmitter: accepts a parallel byte via valid/ready, shifts it out on one serial line.
//  Frame: start(0), DATA_W data bits LSB first, optional even parity, stop(1).
//  Line idles high. Each bit is held CLKS_PER_BIT clocks.
//  Drives the serial link whose far end samples the line with registered capture flops.
// PARAMETERS
//  DATA_W        8   payload width in bits, >=1
//  CLKS_PER_BIT  4   clocks per serial bit, >=1; bit counter width $clog2(CLKS_PER_BIT+1)
// PORTS
//  clk       in   1       clock, rising edge
//  n_rst     in   1       reset, asynchronous, active-low
//  tx_valid  in   1       tx_data holds a frame to send
//  tx_data   in   DATA_W  payload; sampled only on the accept edge
//  tx_ready  out  1       block can accept; =1 only in IDLE (decoded from state register)
//  tx_dout   out  1       serial line, registered
//  tx_busy   out  1       registered; 1 from the accept edge to the end of the stop bit
//  tx_done   out  1       registered 1-cycle pulse after the stop bit completes
// BEHAVIOUR
//  Reset values: state=IDLE, tx_dout=1, tx_busy=0, tx_done=0.
//    Shift register and counters clear to 0. Reset applies immediately, even mid-frame.
//  Reset mid-frame: line returns high at once. The partial frame is dropped; there is no resume.
//  Accept: tx_valid&&tx_ready at a rising edge. On that edge: tx_data latched, state->START,
//    tx_dout<=0, tx_busy<=1. No accept is possible outside IDLE.
//  tx_data changes after the accept edge have no effect on the frame in flight.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    Each bit state lasts exactly CLKS_PER_BIT cycles, timed by the bit counter.
//  Counter rules: bit counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
//    Data index runs 0..DATA_W-1. DATA->next state when index==DATA_W-1 at counter wrap.
//  Data order: bit k of the latched payload is driven during the k-th data bit period (LSB first).
//  Frame length: (DATA_W+2+P)*CLKS_PER_BIT cycles, where P = 1 with PARITY_EN, else 0.
//    Defaults give 40 cycles, or 44 with parity.
//  STOP end: state->IDLE, tx_busy<=0, tx_done<=1 for exactly one cycle, tx_dout stays 1.
//  Back-to-back: tx_ready rises in the first IDLE cycle. The earliest next accept is that edge,
//    so there is at least one idle-high cycle between frames.
//  tx_valid high during a frame is held off (tx_ready=0); no data is lost and none is duplicated.
//  CLKS_PER_BIT=1: one bit per clock; all rules above still hold.
// CONFIGURATION
//  PARITY_EN (`define) compiled in:
//    - PARITY state is inserted between DATA and STOP.
//    - Bit value is even parity: ^payload, so the total count of ones over data+parity is even.
//  PARITY_EN compiled out: the PARITY state and its logic are absent; DATA->STOP directly.
// STRUCTURE
//  Package serial_pkg (shared with the matching receiver):
//    - state encodings ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP (3-bit)
//    - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
//  Sub-module bit_timer:
//    - CLKS_PER_BIT counter with clear input and a tick output on the wrap cycle
//    - also reused by the receiver
//  Top: FSM, shift register, data index, output registers.
// TESTING
//  1 Reset: hold n_rst=0 for 3 cycles -> tx_dout=1, tx_ready=1, tx_busy=0, tx_done=0.
//  2 Send 0xA5, defaults, no parity -> line 0,1,0,1,0,0,1,0,1,1.
//      Each bit held 4 cycles; tx_busy high 40 cycles; tx_done pulses once on cycle 41.
//  3 PARITY_EN:
//      0xA5 -> parity bit 0 and frame 44 cycles.
//      0x01 -> parity bit 1.
//  4 tx_valid held high with 0x3C then 0xC3 -> two complete frames, one idle-high cycle between.
//      tx_data changed mid-frame does not alter the first frame.
//  5 Pull n_rst low during data bit 3 -> tx_dout=1 immediately, tx_busy=0.
//      A new 0x55 sent after reset is a clean full frame.
//  6 CLKS_PER_BIT=1, 0xFF -> 10-cycle frame: 0,1,1,1,1,1,1,1,1,1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg
//   Definitions shared by the serial transmitter and the matching receiver:
//   the frame state encoding and the fixed line levels of the frame.
//   No ports (package).
package serial_pkg;

    // 3-bit frame state encoding. ST_PARITY exists only in builds with
    // parity enabled, but the encoding is fixed so both ends agree.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps. The tick output
//   is high during the last clock of every bit period. It is used by the
//   transmitter and reused by the receiver.
// Ports
//   clk    in   clock, rising edge
//   n_rst  in   asynchronous active-low reset, clears the count
//   clear  in   hold the count at 0 (no tick while asserted)
//   tick   out  high on the wrap cycle of the bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    // Free-running period counter. Clear parks it at 0, so the first period
    // after clear is released always lasts a full CLKS_PER_BIT clocks.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // With CLKS_PER_BIT=1 the count stays at 0 and every clock is a tick.
    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Frame transmitter. It takes a parallel byte through a valid/ready
//   handshake and shifts the byte out on one serial line as:
//   start(0), DATA_W data bits LSB first, optional even parity, stop(1).
//   The line idles high, and each bit is held for CLKS_PER_BIT clocks.
// Configuration
//   PARITY_EN (define) inserts an even-parity bit between data and stop.
// Ports
//   clk       in   clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   tx_valid  in   tx_data holds a frame to send
//   tx_data   in   payload, sampled only on the accept edge
//   tx_ready  out  high only in IDLE (decoded from the state register)
//   tx_dout   out  serial line, registered
//   tx_busy   out  registered, high from the accept edge to the end of the stop bit
//   tx_done   out  registered one-cycle pulse after the stop bit completes
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_dout,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [IDX_W-1:0]  bit_idx;
    logic              tick;
`ifdef PARITY_EN
    logic              parity_bit;
`endif

    // The timer is held in IDLE, so START always gets a full bit period
    // that counts from the accept edge.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    assign tx_ready = (state == ST_IDLE);

    // Frame sequencer. The line value for the next bit is registered on the
    // tick that ends the current bit. The shift register is consumed from
    // bit 0 upward, so the payload goes out LSB first.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx_dout   <= LINE_IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift_reg <= tx_data;
                        bit_idx   <= '0;
                        state     <= ST_START;
                        tx_dout   <= START_BIT;
                        tx_busy   <= 1'b1;
`ifdef PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state     <= ST_DATA;
                        tx_dout   <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == IDX_LAST) begin
`ifdef PARITY_EN
                            state   <= ST_PARITY;
                            tx_dout <= parity_bit;
`else
                            state   <= ST_STOP;
                            tx_dout <= STOP_BIT;
`endif
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx_dout   <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
`ifdef PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        tx_dout <= STOP_BIT;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        state   <= ST_IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_dout <= LINE_IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx
//   Bench for serial_tx. A cycle model expands each accepted payload into
//   its expected per-clock line levels and queues them. Every clock the
//   queued value is compared with tx_dout, tx_busy, tx_done and tx_ready.
//   A second instance with CLKS_PER_BIT=1 covers the one-bit-per-clock case.
module tb_serial_tx;

    localparam int DATA_W = 8;
    localparam int CPB    = 4;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = (DATA_W + 2 + PAR) * CPB;
    localparam int PAR_IDX   = (DATA_W + 1) * CPB;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_dout, tx_busy, tx_done;

    logic       fast_valid = 1'b0;
    logic [7:0] fast_data = 8'h00;
    logic       fast_ready, fast_dout, fast_busy, fast_done;

    int checks = 0;
    int failures = 0;

    logic exp_q[$];
    logic m_busy = 1'b0;
    logic e_dout, e_busy, e_done;

    typedef struct {
        logic [7:0] data;
        logic [7:0] late_data;
        logic       exp_par;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_dout  (tx_dout),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    serial_tx #(.DATA_W(DATA_W), .CLKS_PER_BIT(1)) dut_fast (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_valid (fast_valid),
        .tx_data  (fast_data),
        .tx_ready (fast_ready),
        .tx_dout  (fast_dout),
        .tx_busy  (fast_busy),
        .tx_done  (fast_done)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Expected line level for every clock of a frame, start bit first.
    task automatic pushFrame(input logic [7:0] d);
        for (int r = 0; r < CPB; r++) exp_q.push_back(1'b0);
        for (int b = 0; b < DATA_W; b++)
            for (int r = 0; r < CPB; r++) exp_q.push_back(d[b]);
`ifdef PARITY_EN
        for (int r = 0; r < CPB; r++) exp_q.push_back(^d);
`endif
        for (int r = 0; r < CPB; r++) exp_q.push_back(1'b1);
    endtask

    // One clock: update the model with the inputs present at the rising
    // edge, then compare the main DUT outputs 1 time unit later.
    task automatic stepCycle();
        @(posedge clk);
        if (!n_rst) begin
            exp_q.delete();
            m_busy = 1'b0;
            e_dout = 1'b1;
            e_busy = 1'b0;
            e_done = 1'b0;
        end else begin
            if (!m_busy && tx_valid) pushFrame(tx_data);
            if (exp_q.size() > 0) begin
                e_dout = exp_q.pop_front();
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_dout = 1'b1;
                e_busy = 1'b0;
                e_done = m_busy;
            end
            m_busy = e_busy;
        end
        #1;
        checkOutput("tx_dout", 32'(tx_dout), 32'(e_dout));
        checkOutput("tx_busy", 32'(tx_busy), 32'(e_busy));
        checkOutput("tx_done", 32'(tx_done), 32'(e_done));
        checkOutput("tx_ready", 32'(tx_ready), 32'(!e_busy));
    endtask

    // Send one frame, change tx_data right after the accept edge, and run
    // until tx_done (bounded). Reports busy length and the level seen in the
    // first clock of the parity slot.
    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] late_d,
                                 output int busy_cnt, output logic par_bit);
        logic seen;
        seen     = 1'b0;
        busy_cnt = 0;
        par_bit  = 1'bx;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int c = 0; c < 200 && !seen; c++) begin
            stepCycle();
            if (c == 0) begin
                tx_valid = 1'b0;
                tx_data  = late_d;
            end
            if (c == PAR_IDX) par_bit = tx_dout;
            if (tx_busy) busy_cnt++;
            if (tx_done) seen = 1'b1;
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int   busy_cnt;
        logic par_bit;
        int   done_cnt;

        vecs[0] = '{data: 8'hA5, late_data: 8'h5A, exp_par: 1'b0};
        vecs[1] = '{data: 8'h01, late_data: 8'hFE, exp_par: 1'b1};
        vecs[2] = '{data: 8'h00, late_data: 8'hFF, exp_par: 1'b0};
        vecs[3] = '{data: 8'hFF, late_data: 8'h00, exp_par: 1'b0};
        vecs[4] = '{data: 8'h80, late_data: 8'h7F, exp_par: 1'b1};

        // Reset held for three clocks.
        #1 n_rst = 1'b0;
        repeat (3) stepCycle();
        checkOutput("rst_dout", 32'(tx_dout), 32'd1);
        checkOutput("rst_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_done", 32'(tx_done), 32'd0);
        checkOutput("rst_fast_dout", 32'(fast_dout), 32'd1);
        n_rst = 1'b1;
        stepCycle();

        // Table of single frames.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data, vecs[i].late_data, busy_cnt, par_bit);
            checkOutput("frame_len", 32'(busy_cnt), 32'(FRAME_LEN));
`ifdef PARITY_EN
            checkOutput("parity_bit", 32'(par_bit), 32'(vecs[i].exp_par));
`else
            checkOutput("stop_slot", 32'(par_bit), 32'd1);
`endif
            stepCycle();
        end

        // tx_valid held high: 0x3C, then 0xC3 is presented mid-frame and must
        // become the second frame only.
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        stepCycle();
        tx_data  = 8'hC3;
        done_cnt = 0;
        for (int c = 0; c < 2 * FRAME_LEN + 8; c++) begin
            stepCycle();
            if (tx_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    stepCycle();
                    tx_valid = 1'b0;
                end
            end
        end
        checkOutput("b2b_frames", 32'(done_cnt), 32'd2);

        // Reset during data bit 3 of 0xA5 (bit 3 is 0, so the line is low).
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        stepCycle();
        tx_valid = 1'b0;
        repeat (17) stepCycle();
        checkOutput("pre_rst_dout", 32'(tx_dout), 32'd0);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midrst_dout", 32'(tx_dout), 32'd1);
        checkOutput("midrst_busy", 32'(tx_busy), 32'd0);
        checkOutput("midrst_ready", 32'(tx_ready), 32'd1);
        repeat (2) stepCycle();
        n_rst = 1'b1;
        stepCycle();
        applyStimulus(8'h55, 8'hAA, busy_cnt, par_bit);
        checkOutput("post_rst_len", 32'(busy_cnt), 32'(FRAME_LEN));
        stepCycle();

        // CLKS_PER_BIT=1 instance, 0xFF: start then nine high clocks, then done.
        fast_valid = 1'b1;
        fast_data  = 8'hFF;
        stepCycle();
        fast_valid = 1'b0;
        checkOutput("fast_start", 32'(fast_dout), 32'd0);
        checkOutput("fast_busy", 32'(fast_busy), 32'd1);
        for (int k = 1; k < 10 + PAR; k++) begin
            stepCycle();
            checkOutput("fast_bit", 32'(fast_dout), 32'd1);
            checkOutput("fast_busy_run", 32'(fast_busy), 32'd1);
        end
        stepCycle();
        checkOutput("fast_end_busy", 32'(fast_busy), 32'd0);
        checkOutput("fast_end_done", 32'(fast_done), 32'd1);
        checkOutput("fast_end_dout", 32'(fast_dout), 32'd1);
        stepCycle();
        checkOutput("fast_done_clr", 32'(fast_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
